// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and constants for the reorder buffer
//
// Purpose: entry-state encoding and destination-field location within an
//          instruction word, shared by reorder_buffer and rob_entry.
// Ports:   none (package).
package rob_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rob_state_e;

  localparam int DEST_LSB = 7;
  localparam int DEST_W   = 5;

endpackage

// File: rtl/rob_entry.sv
// rtl/rob_entry.sv - one reorder-buffer entry: state FSM, tag/dest/value, CDB match
//
// Purpose: holds one in-flight instruction. IDLE -alloc-> WAIT -CDB hit-> DONE
//          -retire-> IDLE; flush forces IDLE.
// Ports:   clk, rst_n       clock, asynchronous active-low reset
//          flush            squash this entry
//          alloc            allocate this entry (top only asserts it when IDLE)
//          alloc_dest/tag   destination register and RS tag to latch
//          retire           entry is at head and being committed
//          cdb_valid/tag/value  packed CDB channels, channel 0 in LSBs
//          done             entry holds a result ready to commit
//          dest, value      latched destination and captured result
module rob_entry
  import rob_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [DEST_W-1:0]         alloc_dest,
  input  logic [TAG_W-1:0]          alloc_tag,
  input  logic                      retire,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
  output logic                      done,
  output logic [DEST_W-1:0]         dest,
  output logic [DATA_W-1:0]         value
);

  rob_state_e          r_state;
  rob_state_e          w_state_nxt;
  logic [DEST_W-1:0]   r_dest;
  logic [TAG_W-1:0]    r_tag;
  logic [DATA_W-1:0]   r_value;
  logic                w_hit;
  logic [DATA_W-1:0]   w_hit_value;

  // Scan from the highest channel down so the lowest matching channel
  // is the last assignment and therefore wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_value = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == r_tag)) begin
        w_hit       = 1'b1;
        w_hit_value = cdb_value[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (alloc)  w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_hit)  w_state_nxt = ST_DONE;
      ST_DONE: if (retire) w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dest  <= '0;
      r_tag   <= '0;
      r_value <= '0;
    end else if (!flush) begin
      if (alloc && (r_state == ST_IDLE)) begin
        r_dest <= alloc_dest;
        r_tag  <= alloc_tag;
      end
      // The allocation cycle is IDLE, so it never snoops the CDB.
      if ((r_state == ST_WAIT) && w_hit) begin
        r_value <= w_hit_value;
      end
    end
  end

  assign done  = (r_state == ST_DONE);
  assign dest  = r_dest;
  assign value = r_value;

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order-commit reorder buffer with CDB snooping
//
// Purpose: allocates entries at tail, snoops NUM_CDB result channels, retires
//          the head entry once per cycle as a registered register-file write.
// Ports:   clk, rst_n                 clock, asynchronous active-low reset
//          alloc_valid/ready/instr/tag/idx   allocation handshake, idx = tail
//          cdb_valid/tag/value        packed CDB channels, channel 0 in LSBs
//          flush                      squash everything next edge
//          commit_valid/wen/dest/value registered retire outputs
//          head_idx, count            head pointer and occupancy
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [31:0]                alloc_instr,
  input  logic [TAG_W-1:0]           alloc_tag,
  output logic [$clog2(DEPTH)-1:0]   alloc_idx,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_value,
  input  logic                       flush,
  output logic                       commit_valid,
  output logic                       commit_wen,
  output logic [DEST_W-1:0]          commit_dest,
  output logic [DATA_W-1:0]          commit_value,
  output logic [$clog2(DEPTH)-1:0]   head_idx,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [IDX_W-1:0]  r_head;
  logic [IDX_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_commit_valid;
  logic              r_commit_wen;
  logic [DEST_W-1:0] r_commit_dest;
  logic [DATA_W-1:0] r_commit_value;

  logic              w_entry_done  [DEPTH];
  logic [DEST_W-1:0] w_entry_dest  [DEPTH];
  logic [DATA_W-1:0] w_entry_value [DEPTH];
  logic              w_alloc_ready;
  logic              w_alloc_fire;
  logic              w_retire;
  logic [DEST_W-1:0] w_head_dest;
  logic [DATA_W-1:0] w_head_value;
  logic              w_unused_instr;

  // Only the destination field is kept per entry.
  assign w_unused_instr = ^{alloc_instr[31:DEST_LSB+DEST_W], alloc_instr[DEST_LSB-1:0]};

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + IDX_W'(1);
  endfunction

  // Occupancy, not pointer equality, separates full from empty.
  assign w_alloc_ready = (r_count < FULL_CNT);
  assign w_alloc_fire  = alloc_valid && w_alloc_ready && !flush;
  assign w_head_dest   = w_entry_dest[r_head];
  assign w_head_value  = w_entry_value[r_head];
  assign w_retire      = w_entry_done[r_head] && !flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    rob_entry #(
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W),
      .NUM_CDB (NUM_CDB)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc      (w_alloc_fire && (r_tail == IDX_W'(gi))),
      .alloc_dest (alloc_instr[DEST_LSB +: DEST_W]),
      .alloc_tag  (alloc_tag),
      .retire     (w_retire && (r_head == IDX_W'(gi))),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .done       (w_entry_done[gi]),
      .dest       (w_entry_dest[gi]),
      .value      (w_entry_value[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_wen   <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_value <= '0;
    end else if (flush) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_wen   <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_value <= '0;
    end else begin
      if (w_alloc_fire) r_tail <= f_inc(r_tail);
      if (w_retire)     r_head <= f_inc(r_head);
      case ({w_alloc_fire, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_commit_valid <= w_retire;
      r_commit_wen   <= w_retire && (w_head_dest != '0);
      if (w_retire) begin
        r_commit_dest  <= w_head_dest;
        r_commit_value <= w_head_value;
      end
    end
  end

  assign alloc_ready  = w_alloc_ready;
  assign alloc_idx    = r_tail;
  assign head_idx     = r_head;
  assign count        = r_count;
  assign commit_valid = r_commit_valid;
  assign commit_wen   = r_commit_wen;
  assign commit_dest  = r_commit_dest;
  assign commit_value = r_commit_value;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer (DEPTH 8 and 5)
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [31:0] alloc_instr = '0;
  logic [3:0]  alloc_tag = '0;
  logic [1:0]  cdb_valid = '0;
  logic [7:0]  cdb_tag = '0;
  logic [63:0] cdb_value = '0;
  logic        flush = 1'b0;

  logic        ready8, ready5, cv8, cv5, wen8, wen5;
  logic [2:0]  idx8, idx5, head8, head5;
  logic [3:0]  count8;
  logic [2:0]  count5;
  logic [4:0]  dest8, dest5;
  logic [31:0] val8, val5;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(8), .TAG_W(4), .DATA_W(32), .NUM_CDB(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(ready8),
    .alloc_instr(alloc_instr), .alloc_tag(alloc_tag), .alloc_idx(idx8),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .flush(flush),
    .commit_valid(cv8), .commit_wen(wen8), .commit_dest(dest8), .commit_value(val8),
    .head_idx(head8), .count(count8));

  reorder_buffer #(.DEPTH(5), .TAG_W(4), .DATA_W(32), .NUM_CDB(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(ready5),
    .alloc_instr(alloc_instr), .alloc_tag(alloc_tag), .alloc_idx(idx5),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .flush(flush),
    .commit_valid(cv5), .commit_wen(wen5), .commit_dest(dest5), .commit_value(val5),
    .head_idx(head5), .count(count5));

  // Reference model: each buffer is a FIFO of in-flight instructions.
  typedef struct {
    logic [4:0]  dest;
    logic [3:0]  tag;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        mq [2][$];
  int          m_depth [2] = '{8, 5};
  int          m_head [2];
  int          m_tail [2];
  bit          m_cv [2];
  bit          m_wen [2];
  logic [4:0]  m_dest [2];
  logic [31:0] m_val [2];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_head[k] = 0; m_tail[k] = 0;
      m_cv[k] = 0; m_wen[k] = 0; m_dest[k] = '0; m_val[k] = '0;
    end
  endtask

  task automatic model_edge(input int k);
    ent_t e;
    bit   ret, rdy;
    if (flush) begin
      mq[k].delete();
      m_head[k] = 0; m_tail[k] = 0;
      m_cv[k] = 0; m_wen[k] = 0; m_dest[k] = '0; m_val[k] = '0;
      return;
    end
    rdy = mq[k].size() < m_depth[k];
    ret = (mq[k].size() > 0) && mq[k][0].done;
    for (int i = 0; i < mq[k].size(); i++) begin
      e = mq[k][i];
      if (!e.done) begin
        for (int c = 0; c < 2; c++) begin
          if (cdb_valid[c] && (cdb_tag[c*4 +: 4] == e.tag)) begin
            e.done = 1; e.val = cdb_value[c*32 +: 32];
            break;
          end
        end
        mq[k][i] = e;
      end
    end
    m_cv[k] = ret;
    m_wen[k] = 0;
    if (ret) begin
      e = mq[k].pop_front();
      m_wen[k] = (e.dest != 0);
      m_dest[k] = e.dest;
      m_val[k] = e.val;
      m_head[k] = (m_head[k] + 1) % m_depth[k];
    end
    if (alloc_valid && rdy) begin
      e.dest = alloc_instr[11:7]; e.tag = alloc_tag; e.done = 0; e.val = '0;
      mq[k].push_back(e);
      m_tail[k] = (m_tail[k] + 1) % m_depth[k];
    end
  endtask

  task automatic cmp(input int k, input int cnt, input int hd, input int rdy, input int idx,
                     input int cv, input int wen, input int dst, input logic [31:0] val);
    string p;
    p = (k == 0) ? "d8" : "d5";
    chk({p, "_count"}, cnt, mq[k].size());
    chk({p, "_head"}, hd, m_head[k]);
    chk({p, "_ready"}, rdy, (mq[k].size() < m_depth[k]) ? 1 : 0);
    chk({p, "_alloc_idx"}, idx, m_tail[k]);
    chk({p, "_commit_valid"}, cv, m_cv[k]);
    chk({p, "_commit_wen"}, wen, m_wen[k]);
    if (m_cv[k]) begin
      chk({p, "_commit_dest"}, dst, m_dest[k]);
      chk({p, "_commit_value"}, val, m_val[k]);
    end
  endtask

  task automatic cmp_all();
    cmp(0, int'(count8), int'(head8), int'(ready8), int'(idx8), int'(cv8), int'(wen8), int'(dest8), val8);
    cmp(1, int'(count5), int'(head5), int'(ready5), int'(idx5), int'(cv5), int'(wen5), int'(dest5), val5);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic drive(input bit av, input logic [4:0] d, input logic [3:0] t,
                       input logic [1:0] cv, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [31:0] v0, input logic [31:0] v1, input bit fl);
    alloc_valid = av;
    alloc_instr = {20'h12345, d, 7'h33};
    alloc_tag   = t;
    cdb_valid   = cv;
    cdb_tag     = {t1, t0};
    cdb_value   = {v1, v0};
    flush       = fl;
  endtask

  task automatic idle();
    drive(0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 0);
  endtask

  typedef struct packed {
    logic        av;
    logic [4:0]  dest;
    logic [3:0]  tag;
    logic [1:0]  cv;
    logic [3:0]  t0;
    logic [3:0]  t1;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [3:0]  ecount;
    logic        ecv;
    logic        ewen;
    logic [4:0]  edest;
    logic [31:0] evalue;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{1'b1, 5'd1, 4'd1, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{1'b1, 5'd2, 4'd2, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd2, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[2]  = '{1'b1, 5'd3, 4'd3, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd3, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 4'd0, 2'b11, 4'd2, 4'd3, 32'h22, 32'h33, 4'd3, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd3, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[5]  = '{1'b0, 5'd0, 4'd0, 2'b01, 4'd1, 4'd0, 32'h11, 32'h0, 4'd3, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[6]  = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd2, 1'b1, 1'b1, 5'd1, 32'h11};
    tbl[7]  = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1, 1'b1, 1'b1, 5'd2, 32'h22};
    tbl[8]  = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 5'd3, 32'h33};
    tbl[9]  = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[10] = '{1'b1, 5'd0, 4'd6, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[11] = '{1'b0, 5'd0, 4'd0, 2'b01, 4'd6, 4'd0, 32'hDEADBEEF, 32'h0, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[12] = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 5'd4, 4'd4, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[14] = '{1'b1, 5'd5, 4'd5, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd2, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[15] = '{1'b0, 5'd0, 4'd0, 2'b11, 4'd4, 4'd5, 32'h44, 32'h55, 4'd2, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[16] = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1, 1'b1, 1'b1, 5'd4, 32'h44};
    tbl[17] = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 5'd5, 32'h55};
    tbl[18] = '{1'b1, 5'd7, 4'd7, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[19] = '{1'b0, 5'd0, 4'd0, 2'b11, 4'd7, 4'd7, 32'hAAA, 32'hBBB, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[20] = '{1'b0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 5'd7, 32'hAAA};

    // Reset state
    m_reset();
    idle();
    repeat (2) @(negedge clk);
    cmp_all();
    chk("reset_dest8", dest8, 0);
    chk("reset_value8", val8, 0);
    rst_n = 1'b1;

    // Directed table on the DEPTH=8 instance
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].av, tbl[i].dest, tbl[i].tag, tbl[i].cv, tbl[i].t0, tbl[i].t1,
            tbl[i].v0, tbl[i].v1, 0);
      step();
      chk($sformatf("tbl%0d_count", i), count8, tbl[i].ecount);
      chk($sformatf("tbl%0d_cv", i), cv8, tbl[i].ecv);
      if (tbl[i].ecv) begin
        chk($sformatf("tbl%0d_wen", i), wen8, tbl[i].ewen);
        chk($sformatf("tbl%0d_dest", i), dest8, tbl[i].edest);
        chk($sformatf("tbl%0d_value", i), val8, tbl[i].evalue);
      end
    end

    // Fill to capacity, overflow attempt, then a retire frees one slot
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(8 + i), 4'(8 + i), 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 0);
      step();
    end
    chk("full_count", count8, 8);
    chk("full_ready", ready8, 0);
    drive(1, 5'd20, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 0);
    step();
    chk("overflow_count", count8, 8);
    drive(0, 5'd0, 4'd0, 2'b01, 4'd8, 4'd0, 32'h808, 32'h0, 0);
    step();
    idle();
    step();
    chk("after_retire_count", count8, 7);
    chk("after_retire_ready", ready8, 1);

    // Flush wins over alloc, CDB capture and a pending retire
    drive(0, 5'd0, 4'd0, 2'b01, 4'd9, 4'd0, 32'h909, 32'h0, 0);
    step();
    drive(1, 5'd1, 4'd1, 2'b01, 4'd10, 4'd0, 32'hA0A, 32'h0, 1);
    step();
    chk("flush_count", count8, 0);
    chk("flush_cv", cv8, 0);
    drive(1, 5'd1, 4'd1, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 0);
    #1 chk("post_flush_idx", idx8, 0);
    step();
    chk("post_flush_count", count8, 1);
    drive(0, 5'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1);
    step();

    // Pointer wrap: 12 alloc/complete/retire rounds
    for (int i = 0; i < 12; i++) begin
      drive(1, 5'(i + 1), 4'(i), 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 0);
      step();
      drive(0, 5'd0, 4'd0, 2'b10, 4'd15, 4'(i), 32'h0, 32'hC000 + 32'(i), 0);
      step();
      idle();
      step();
      chk($sformatf("wrap%0d_cv5", i), cv5, 1);
      chk($sformatf("wrap%0d_dest5", i), dest5, i + 1);
      chk($sformatf("wrap%0d_val5", i), val5, 32'hC000 + 32'(i));
    end
    chk("wrap_head5", head5, 2);
    chk("wrap_head8", head8, 4);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom_range(0, 99) < 3);
      step();
    end

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    cmp_all();
    chk("async_cv8", cv8, 0);
    chk("async_count5", count5, 0);
    #1 rst_n = 1'b1;
    idle();
    step();
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 99) < 70, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            $urandom, $urandom, 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
